// File: rtl/libv_pkg.sv
// Shared types for the deque command scheduler: deque op encoding,
// scheduler FSM states and a push/pop classifier.
package libv_pkg;

  typedef enum logic [1:0] {
    OpPushFront = 2'd0,
    OpPopFront  = 2'd1,
    OpPushBack  = 2'd2,
    OpPopBack   = 2'd3
  } deque_op_t;

  typedef enum logic {
    StIdle  = 1'b0,
    StFlush = 1'b1
  } sched_state_t;

  function automatic logic is_push(deque_op_t op);
    return (op == OpPushFront) || (op == OpPushBack);
  endfunction

endpackage

// File: rtl/libv_deque_sched_if.sv
// Bundle of client request, deque command, response and status signals
// around libv_deque_sched. master = client/deque side, slave = scheduler.
interface libv_deque_sched_if #(
  parameter int W = 32,
  parameter int N = 8
);
  import libv_pkg::*;
  localparam int CW = $clog2(N + 1);

  // Handshakes: a request transfers on the edge where in_vld & in_rdy, a
  // response on the edge where rsp_vld & rsp_rdy; valid never waits on ready.
  logic            in_vld;
  deque_op_t       in_op;
  logic [W-1:0]    in_data;
  logic            in_rdy;
  logic            flush_req;
  logic            flush_done;
  logic            cmd_vld;
  deque_op_t       cmd_op;
  logic [W-1:0]    cmd_push_data;
  logic [W-1:0]    cmd_pop_data;
  logic            rsp_vld;
  logic            rsp_rdy;
  deque_op_t       rsp_op;
  logic [W-1:0]    rsp_data;
  logic            rsp_err;
  logic [CW-1:0]   cnt_r;
  logic            empty_r;
  logic            full_r;
  logic [15:0]     err_cnt_r;

  modport master (
    output in_vld, in_op, in_data, flush_req, cmd_pop_data, rsp_rdy,
    input  in_rdy, flush_done, cmd_vld, cmd_op, cmd_push_data,
           rsp_vld, rsp_op, rsp_data, rsp_err, cnt_r, empty_r, full_r, err_cnt_r
  );

  modport slave (
    input  in_vld, in_op, in_data, flush_req, cmd_pop_data, rsp_rdy,
    output in_rdy, flush_done, cmd_vld, cmd_op, cmd_push_data,
           rsp_vld, rsp_op, rsp_data, rsp_err, cnt_r, empty_r, full_r, err_cnt_r
  );

endinterface

// File: rtl/libv_deque_sched_rsp.sv
// One-entry response register: loads on accept, clears when consumed,
// and a load in the same cycle as a consume simply overwrites.
module libv_deque_sched_rsp
  import libv_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  deque_op_t    load_op_i,
  input  logic         load_err_i,
  input  logic [W-1:0] load_data_i,
  input  logic         rdy_i,
  output logic         vld_o,
  output deque_op_t    op_o,
  output logic         err_o,
  output logic [W-1:0] data_o
);

  logic         vld_q;
  deque_op_t    op_q;
  logic         err_q;
  logic [W-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= 1'b0;
      op_q   <= OpPushFront;
      err_q  <= 1'b0;
      data_q <= '0;
    end else if (load_i) begin
      vld_q  <= 1'b1;
      op_q   <= load_op_i;
      err_q  <= load_err_i;
      data_q <= load_data_i;
    end else if (rdy_i) begin
      vld_q  <= 1'b0;
    end
  end

  assign vld_o  = vld_q;
  assign op_o   = op_q;
  assign err_o  = err_q;
  assign data_o = data_q;

endmodule

// File: rtl/libv_deque_sched.sv
// Command scheduler in front of libv_deque: legality checks, occupancy and
// flush FSM. Define LIBV_DEQUE_SCHED_STATS_EN to enable the error counter.
module libv_deque_sched
  import libv_pkg::*;
#(
  parameter int W = 32,
  parameter int N = 8
) (
  input  logic                clk,
  input  logic                rst,
  libv_deque_sched_if.slave   bus,
  output sched_state_t        dbg_state_o
);

  localparam int CW = $clog2(N + 1);

  sched_state_t  state_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          empty_q, full_q, flush_done_q;
  logic          idle, accept, push, legal, issue, flush_pop, rsp_vld;

  assign idle      = (state_q == StIdle);
  assign bus.in_rdy = idle & ~bus.flush_req & (~rsp_vld | bus.rsp_rdy);
  assign accept    = bus.in_vld & bus.in_rdy;
  assign push      = is_push(bus.in_op);
  assign legal     = push ? ~full_q : ~empty_q;
  assign issue     = accept & legal;
  assign flush_pop = ~idle & (cnt_q != '0);

  assign bus.cmd_vld       = issue | flush_pop;
  assign bus.cmd_op        = flush_pop ? OpPopFront : bus.in_op;
  assign bus.cmd_push_data = bus.in_data;

  always_comb begin
    cnt_d = cnt_q;
    if (flush_pop)  cnt_d = cnt_q - CW'(1);
    else if (issue) cnt_d = push ? cnt_q + CW'(1) : cnt_q - CW'(1);
  end

  // flush_done is raised on entry to the FLUSH cycle that sees an empty deque.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      flush_done_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          flush_done_q <= bus.flush_req & (cnt_q == '0);
          if (bus.flush_req) state_q <= StFlush;
        end
        StFlush: begin
          flush_done_q <= (cnt_q == CW'(1));
          if (cnt_q == '0) state_q <= StIdle;
        end
        default: begin
          flush_done_q <= 1'b0;
          state_q      <= StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      empty_q <= (cnt_d == '0);
      full_q  <= (cnt_d == CW'(N));
    end
  end

  libv_deque_sched_rsp #(.W(W)) u_rsp (
    .clk         (clk),
    .rst         (rst),
    .load_i      (accept),
    .load_op_i   (bus.in_op),
    .load_err_i  (~legal),
    .load_data_i ((legal & ~push) ? bus.cmd_pop_data : '0),
    .rdy_i       (bus.rsp_rdy),
    .vld_o       (rsp_vld),
    .op_o        (bus.rsp_op),
    .err_o       (bus.rsp_err),
    .data_o      (bus.rsp_data)
  );

`ifdef LIBV_DEQUE_SCHED_STATS_EN
  logic [15:0] err_cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                            err_cnt_q <= '0;
    else if (accept & ~legal & (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 16'd1;
  end
  assign bus.err_cnt_r = err_cnt_q;
`else
  assign bus.err_cnt_r = '0;
`endif

  assign bus.rsp_vld    = rsp_vld;
  assign bus.flush_done = flush_done_q;
  assign bus.cnt_r      = cnt_q;
  assign bus.empty_r    = empty_q;
  assign bus.full_r     = full_q;
  assign dbg_state_o    = state_q;

  a_cnt_bound: assert property (@(posedge clk) disable iff (rst) cnt_q <= CW'(N));

endmodule

// File: tb/tb_libv_deque_sched.sv
// Directed bench for libv_deque_sched: a queue-based deque/response model is
// compared against the DUT every cycle, plus hand-computed literal checks.
module tb_libv_deque_sched;
  import libv_pkg::*;

  localparam int W  = 32;
  localparam int N  = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  sched_state_t dbg_state;

  libv_deque_sched_if #(.W(W), .N(N)) bus ();

  libv_deque_sched #(.W(W), .N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: deque contents, flush mode and the pending response.
  logic [W-1:0] m_q[$];
  logic         m_flush;
  logic         m_rsp_vld;
  logic         m_rsp_err;
  deque_op_t    m_rsp_op;
  logic [W-1:0] m_rsp_data;
  int           m_err_cnt;

  int   flush_pops;
  int   fd_pulses;
  logic last_cmd_vld;
  logic last_in_rdy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic op_is_push(input deque_op_t op);
    return (op == OpPushFront) || (op == OpPushBack);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_flush    = 1'b0;
    m_rsp_vld  = 1'b0;
    m_rsp_err  = 1'b0;
    m_rsp_op   = OpPushFront;
    m_rsp_data = '0;
    m_err_cnt  = 0;
  endtask

  task automatic cmp_regs();
    chk("rsp_vld",    32'(bus.rsp_vld),   32'(m_rsp_vld));
    chk("rsp_op",     32'(bus.rsp_op),    32'(m_rsp_op));
    chk("rsp_err",    32'(bus.rsp_err),   32'(m_rsp_err));
    chk("rsp_data",   bus.rsp_data,       m_rsp_data);
    chk("cnt_r",      32'(bus.cnt_r),     32'(m_q.size()));
    chk("empty_r",    32'(bus.empty_r),   32'(m_q.size() == 0));
    chk("full_r",     32'(bus.full_r),    32'(m_q.size() == N));
    chk("flush_done", 32'(bus.flush_done), 32'(m_flush && m_q.size() == 0));
    chk("err_cnt_r",  32'(bus.err_cnt_r), 32'(m_err_cnt));
    chk("state",      32'(dbg_state),     32'(m_flush ? StFlush : StIdle));
  endtask

  // One clock cycle: drive, check combinational outputs, advance the model at
  // the edge, then compare registered outputs half a cycle later.
  task automatic step(input logic vld, input deque_op_t op, input logic [W-1:0] data,
                      input logic flush, input logic rdy);
    logic         e_rdy, acc, psh, legal, e_cmd, fpop;
    logic [W-1:0] pd;
    psh   = op_is_push(op);
    legal = psh ? (m_q.size() < N) : (m_q.size() > 0);
    e_rdy = !m_flush && !flush && (!m_rsp_vld || rdy);
    acc   = vld && e_rdy;
    fpop  = m_flush && (m_q.size() > 0);
    e_cmd = (acc && legal) || fpop;
    pd    = 32'hDEAD_BEEF;
    if (!psh && legal) pd = (op == OpPopFront) ? m_q[0] : m_q[m_q.size()-1];

    bus.in_vld       = vld;
    bus.in_op        = op;
    bus.in_data      = data;
    bus.flush_req    = flush;
    bus.rsp_rdy      = rdy;
    bus.cmd_pop_data = pd;
    #1;
    chk("in_rdy",  32'(bus.in_rdy),  32'(e_rdy));
    chk("cmd_vld", 32'(bus.cmd_vld), 32'(e_cmd));
    if (e_cmd) chk("cmd_op", 32'(bus.cmd_op), 32'(fpop ? OpPopFront : op));
    if (acc && legal && psh) chk("cmd_push_data", bus.cmd_push_data, data);
    last_cmd_vld = bus.cmd_vld;
    last_in_rdy  = bus.in_rdy;
    if (m_flush && bus.cmd_vld && bus.cmd_op == OpPopFront) flush_pops++;

    @(posedge clk);
    if (m_flush) begin
      if (m_q.size() == 0) m_flush = 1'b0;
      else void'(m_q.pop_front());
    end else if (flush) begin
      m_flush = 1'b1;
    end
    if (acc) begin
      m_rsp_vld  = 1'b1;
      m_rsp_op   = op;
      m_rsp_err  = !legal;
      m_rsp_data = (legal && !psh) ? pd : '0;
      if (legal) begin
        case (op)
          OpPushFront: m_q.push_front(data);
          OpPushBack:  m_q.push_back(data);
          OpPopFront:  void'(m_q.pop_front());
          default:     void'(m_q.pop_back());
        endcase
      end
`ifdef LIBV_DEQUE_SCHED_STATS_EN
      if (!legal && m_err_cnt < 65535) m_err_cnt++;
`endif
    end else if (rdy) begin
      m_rsp_vld = 1'b0;
    end

    @(negedge clk);
    #1;
    cmp_regs();
    if (bus.flush_done) fd_pulses++;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, OpPushFront, '0, 1'b0, rdy);
  endtask

  task automatic do_reset();
    rst              = 1'b1;
    bus.in_vld       = 1'b0;
    bus.in_op        = OpPushFront;
    bus.in_data      = '0;
    bus.flush_req    = 1'b0;
    bus.rsp_rdy      = 1'b0;
    bus.cmd_pop_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    cmp_regs();
  endtask

  initial begin
    // Reset values
    do_reset();
    chk("rst_cnt",        32'(bus.cnt_r),      32'd0);
    chk("rst_empty",      32'(bus.empty_r),    32'd1);
    chk("rst_full",       32'(bus.full_r),     32'd0);
    chk("rst_rsp_vld",    32'(bus.rsp_vld),    32'd0);
    chk("rst_rsp_op",     32'(bus.rsp_op),     32'(OpPushFront));
    chk("rst_flush_done", 32'(bus.flush_done), 32'd0);
    chk("rst_err_cnt",    32'(bus.err_cnt_r),  32'd0);
    chk("rst_in_rdy",     32'(bus.in_rdy),     32'd1);

    // Push A, push B, pop front returns A
    step(1'b1, OpPushBack, 32'hA, 1'b0, 1'b1);
    chk("t1_cmd0", 32'(last_cmd_vld), 32'd1);
    chk("t1_cnt0", 32'(bus.cnt_r), 32'd1);
    step(1'b1, OpPushBack, 32'hB, 1'b0, 1'b1);
    chk("t1_cmd1", 32'(last_cmd_vld), 32'd1);
    chk("t1_cnt1", 32'(bus.cnt_r), 32'd2);
    step(1'b1, OpPopFront, '0, 1'b0, 1'b1);
    chk("t1_cmd2", 32'(last_cmd_vld), 32'd1);
    chk("t1_cnt2", 32'(bus.cnt_r), 32'd1);
    chk("t1_data", bus.rsp_data, 32'hA);
    chk("t1_err",  32'(bus.rsp_err), 32'd0);
    idle(1'b1);

    // Pop on empty
    do_reset();
    step(1'b1, OpPopBack, '0, 1'b0, 1'b1);
    chk("t2_cmd",  32'(last_cmd_vld), 32'd0);
    chk("t2_err",  32'(bus.rsp_err), 32'd1);
    chk("t2_data", bus.rsp_data, 32'd0);
    chk("t2_cnt",  32'(bus.cnt_r), 32'd0);
`ifdef LIBV_DEQUE_SCHED_STATS_EN
    chk("t2_errcnt", 32'(bus.err_cnt_r), 32'd1);
`else
    chk("t2_errcnt", 32'(bus.err_cnt_r), 32'd0);
`endif

    // Nine pushes into an 8-deep deque
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, OpPushFront, 32'h100 + i, 1'b0, 1'b1);
    chk("t3_full", 32'(bus.full_r), 32'd1);
    chk("t3_cnt8", 32'(bus.cnt_r), 32'd8);
    step(1'b1, OpPushFront, 32'h1FF, 1'b0, 1'b1);
    chk("t3_err9", 32'(bus.rsp_err), 32'd1);
    chk("t3_cmd9", 32'(last_cmd_vld), 32'd0);
    chk("t3_cnt9", 32'(bus.cnt_r), 32'd8);
    step(1'b1, OpPopBack, '0, 1'b0, 1'b1);
    chk("t3_popback", bus.rsp_data, 32'h100);

    // Backpressure then overwrite on back-to-back accept
    do_reset();
    step(1'b1, OpPushFront, 32'h11, 1'b0, 1'b0);
    step(1'b1, OpPushBack, 32'h22, 1'b0, 1'b0);
    chk("t4_stall_rdy", 32'(last_in_rdy), 32'd0);
    chk("t4_hold_op",   32'(bus.rsp_op), 32'(OpPushFront));
    step(1'b1, OpPushBack, 32'h55, 1'b0, 1'b1);
    chk("t4_go_rdy", 32'(last_in_rdy), 32'd1);
    chk("t4_ovr_op", 32'(bus.rsp_op), 32'(OpPushBack));
    chk("t4_cnt",    32'(bus.cnt_r), 32'd2);
    idle(1'b1);
    chk("t4_drain", 32'(bus.rsp_vld), 32'd0);

    // Flush of 5 entries with a pending response held
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, OpPushBack, 32'h200 + i, 1'b0, 1'b1);
    flush_pops = 0;
    fd_pulses  = 0;
    step(1'b1, OpPushBack, 32'h2FF, 1'b1, 1'b0);
    chk("t5_flush_rdy", 32'(last_in_rdy), 32'd0);
    step(1'b1, OpPushBack, 32'h2FE, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) idle(1'b0);
    chk("t5_pops",    32'(flush_pops), 32'd5);
    chk("t5_done",    32'(fd_pulses), 32'd1);
    chk("t5_cnt",     32'(bus.cnt_r), 32'd0);
    chk("t5_empty",   32'(bus.empty_r), 32'd1);
    chk("t5_rsp_hold", 32'(bus.rsp_vld), 32'd1);
    idle(1'b1);
    chk("t5_rsp_drain", 32'(bus.rsp_vld), 32'd0);

    // Flush on an empty deque
    fd_pulses = 0;
    step(1'b0, OpPushFront, '0, 1'b1, 1'b1);
    chk("t5b_done", 32'(bus.flush_done), 32'd1);
    idle(1'b1);
    chk("t5b_idle", 32'(dbg_state), 32'(StIdle));
    chk("t5b_pulses", 32'(fd_pulses), 32'd1);

    // Reset two cycles into a flush of 6
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, OpPushFront, 32'h300 + i, 1'b0, 1'b1);
    fd_pulses = 0;
    step(1'b0, OpPushFront, '0, 1'b1, 1'b1);
    idle(1'b1);
    idle(1'b1);
    rst = 1'b1;
    model_reset();
    #1;
    chk("t6_cnt",   32'(bus.cnt_r), 32'd0);
    chk("t6_vld",   32'(bus.rsp_vld), 32'd0);
    chk("t6_done",  32'(bus.flush_done), 32'd0);
    chk("t6_state", 32'(dbg_state), 32'(StIdle));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) idle(1'b1);
    chk("t6_no_done", 32'(fd_pulses), 32'd0);
    chk("t6_cnt_end", 32'(bus.cnt_r), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/libv_deque_sched.md
Name: libv_deque_sched

Overview:
Command scheduler that sits directly upstream of the libv_deque storage block and drives its command port.
- Accepts deque requests from a client over a valid/ready handshake.
- Tracks occupancy and rejects illegal ops (push when full, pop when empty) instead of forwarding them.
- Returns one registered response per accepted request.
- Provides a flush sequence that drains the deque with back-to-back front pops.

Parameters:
W, 32, data word width; equals the downstream deque W.
N, 8, deque capacity in words; equals the downstream deque N; power of two, at least 2.

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
in_vld  in  1  request valid
in_op  in  libv_pkg::deque_op_t  requested op
in_data  in  W  push data
in_rdy  out  1  request accepted when in_vld & in_rdy
flush_req  in  1  start flush; sampled only in IDLE
flush_done  out  1  one-cycle pulse when flush completes
cmd_vld  out  1  to deque
cmd_op  out  libv_pkg::deque_op_t  to deque
cmd_push_data  out  W  to deque
cmd_pop_data  in  W  from deque; combinational pop data
rsp_vld  out  1  response valid
rsp_rdy  in  1  response consumed when rsp_vld & rsp_rdy
rsp_op  out  libv_pkg::deque_op_t  op of the responded request
rsp_data  out  W  pop data; 0 for push or error
rsp_err  out  1  request was illegal and was not issued
cnt_r  out  $clog2(N+1)  occupancy
empty_r  out  1  cnt_r == 0
full_r  out  1  cnt_r == N
err_cnt_r  out  16  illegal-request count (see Optional Feature)

Behaviour:
- Reset (async, active-high): state IDLE, cnt_r=0, empty_r=1, full_r=0, rsp_vld=0, rsp_err=0, rsp_data=0, rsp_op=OpPushFront, flush_done=0, err_cnt_r=0.
- FSM has two states, IDLE and FLUSH.
- IDLE:
  - in_rdy = ~flush_req & (~rsp_vld | rsp_rdy).
  - Accept = in_vld & in_rdy.
  - legal = push ? ~full_r : ~empty_r.
- Issue rules:
  - cmd_vld = accept & legal, in the same cycle (combinational); cmd_op = in_op; cmd_push_data = in_data.
  - Illegal requests drive cmd_vld=0.
- Response rules:
  - On accept, the response register loads at the next edge: rsp_vld=1, rsp_op=in_op, rsp_err=~legal.
  - rsp_data = cmd_pop_data for a legal pop, else 0.
  - Latency is exactly one cycle from accept to rsp_vld.
  - rsp_vld clears on rsp_rdy when there is no new accept.
  - A new accept and a response consume in the same cycle overwrite the register: full throughput, one request per cycle.
- Occupancy:
  - cnt_r +1 on a legal push, -1 on a legal pop, no change on an illegal request.
  - empty_r and full_r are registered from the next cnt.
- Flush:
  - flush_req in IDLE has priority over in_vld: in_rdy=0 that cycle; next state FLUSH.
  - In FLUSH: in_rdy=0. While cnt_r>0, cmd_vld=1 with cmd_op=OpPopFront, cnt_r decrements, and no responses are generated.
  - When cnt_r==0 in FLUSH: flush_done=1 for one cycle, then return to IDLE.
  - Flush on an empty deque takes IDLE, then FLUSH with flush_done, then IDLE.
  - A pending response (rsp_vld) is held through flush and is still drained by rsp_rdy.
- Reset mid-flush aborts to IDLE with cnt_r=0; the deque must share the same rst.
- cnt arithmetic is unsigned; underflow and overflow are impossible by the legality checks. An assertion fires if cnt_r > N.

Optional Feature:
Macro LIBV_DEQUE_SCHED_STATS_EN.
- Defined: err_cnt_r increments on each accepted illegal request, saturating at 16'hFFFF; it resets to 0 on rst only (flush does not clear it).
- Undefined: err_cnt_r is tied to 0 and no counter flops are instantiated.

Decomposition:
- libv_pkg holds:
  - deque_op_t: 2-bit enum, OpPushFront/OpPopFront/OpPushBack/OpPopBack.
  - A helper function is_push(op).
  - The scheduler state enum (IDLE/FLUSH).
- One natural sub-module: libv_deque_sched_rsp, a one-entry response register with valid/ready, load and overwrite. The FSM, legality checks and counter stay in the parent.

Test Plan:
- Reset, then PushBack 0xA, PushBack 0xB, PopFront with rsp_rdy=1 -> cmd_vld every accept cycle; third response rsp_data=0xA, rsp_err=0; cnt_r sequence 1,2,1.
- Pop on empty after reset -> cmd_vld=0, rsp_err=1, rsp_data=0, cnt_r=0; with STATS_EN, err_cnt_r=1.
- N=8: nine PushFront requests -> first 8 issued and full_r=1 after the 8th; 9th gives rsp_err=1, no cmd_vld, cnt_r=8.
- Hold rsp_rdy=0 after one accept -> in_rdy=0, rsp fields stable; raise rsp_rdy -> in_rdy=1 and the back-to-back accept overwrites the register in the same cycle.
- Fill 5 entries, pulse flush_req with in_vld=1 -> in_rdy=0; 5 consecutive OpPopFront cmd_vld cycles; flush_done pulses once; cnt_r=0, empty_r=1; no responses generated.
- Assert rst two cycles into a flush of 6 entries -> immediate IDLE, cnt_r=0, rsp_vld=0, flush_done never pulses.
